// File: rtl/maxpool2x2.sv
// 2x2 / stride-2 max pooling over one feature-map channel, streaming, no stall path.
// Optional MAXPOOL_RELU_EN fuses a ReLU into the output register stage.
module maxpool2x2 #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned IMG_WIDTH  = 10,
    parameter int unsigned IMG_HEIGHT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int unsigned HALF_W = IMG_WIDTH / 2;
    localparam int unsigned HALF_H = IMG_HEIGHT / 2;
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam bit          H_ODD  = (IMG_HEIGHT % 2) == 1;

    logic [COL_W-1:0]             r_col;
    logic [ROW_W-1:0]             r_row;
    logic signed [DATA_WIDTH-1:0] r_hold;
    logic signed [DATA_WIDTH-1:0] r_linebuf [HALF_W];

    logic                         w_col_last;
    logic                         w_row_last;
    logic                         w_row_used;
    logic [IDX_W-1:0]             w_idx;
    logic signed [DATA_WIDTH-1:0] w_din;
    logic signed [DATA_WIDTH-1:0] w_hmax;
    logic signed [DATA_WIDTH-1:0] w_lb_rd;
    logic signed [DATA_WIDTH-1:0] w_pool;
    logic signed [DATA_WIDTH-1:0] w_result;
    logic                         w_lb_wr;
    logic                         w_out_fire;
    logic                         w_last_win;

    // Window position decode and signed max datapath.
    always_comb begin
        w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
        w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));
        w_row_used = !(H_ODD && w_row_last);
        w_idx      = IDX_W'(r_col >> 1);
        w_din      = data_in;
        w_hmax     = (w_din > r_hold) ? w_din : r_hold;
        w_lb_rd    = r_linebuf[w_idx];
        w_pool     = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;
`ifdef MAXPOOL_RELU_EN
        w_result   = w_pool[DATA_WIDTH-1] ? '0 : w_pool;
`else
        w_result   = w_pool;
`endif
        w_lb_wr    = valid_in && r_col[0] && !r_row[0] && w_row_used;
        w_out_fire = valid_in && r_col[0] && r_row[0];
        w_last_win = (r_col == COL_W'(2 * HALF_W - 1)) && (r_row == ROW_W'(2 * HALF_H - 1));
    end

    // Raster counters, left pixel hold and half-row buffer of horizontal maxima.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hold <= '0;
            for (int i = 0; i < int'(HALF_W); i++) begin
                r_linebuf[i] <= '0;
            end
        end else if (valid_in) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
            if (!r_col[0]) begin
                r_hold <= w_din;
            end
            if (w_lb_wr) begin
                r_linebuf[w_idx] <= w_hmax;
            end
        end
    end

    // Registered outputs; data_out holds between pooled pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= w_out_fire;
            frame_done <= w_out_fire && w_last_win;
            if (w_out_fire) begin
                data_out <= w_result;
            end
        end
    end

endmodule
